// File: rtl/acsp_pkg.sv
// rtl/acsp_pkg.sv - shared readout state type, byte-count helper and watchdog default
package acsp_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        SEND      = 3'd3,
        WAIT_HI   = 3'd4,
        WAIT_LO   = 3'd5,
        DONE      = 3'd6
    } readout_state_t;

    function automatic int bytes_per_sample(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// rtl/tx_byte_handshake.sv - one-byte UART handshake (SEND/WAIT_HI/WAIT_LO), optional READOUT_TIMEOUT_EN watchdog
module tx_byte_handshake
    import acsp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_abort,
    input  logic       i_byte_req,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_byte,
    output logic       o_byte_done,
    output logic       o_timeout_hit
);

    readout_state_t r_state;
    readout_state_t w_next;
    logic           r_tx_start;
    logic [7:0]     r_tx_byte;
    logic           w_issue;
    logic           w_byte_done;
    logic           w_timeout;
    logic           w_tmo_hit;

`ifdef READOUT_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;

    // watchdog: cycles spent in the current wait state, restarting on every state change
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (w_next != r_state) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_HI || r_state == WAIT_LO) begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
    end

    assign w_tmo_hit = (r_state == WAIT_HI || r_state == WAIT_LO) &&
                       (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // no watchdog: the limit only feeds this always-false compare
    assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // byte finished: UART dropped busy after accepting the request
    assign w_byte_done = (r_state == WAIT_LO) && !i_tx_busy && !i_abort;

    // watchdog only fires while the awaited busy edge has not arrived
    assign w_timeout = w_tmo_hit && !i_abort &&
                       (((r_state == WAIT_HI) && !i_tx_busy) ||
                        ((r_state == WAIT_LO) &&  i_tx_busy));

    assign o_byte_done   = w_byte_done;
    assign o_timeout_hit = w_timeout;
    assign o_tx_start    = r_tx_start;
    assign o_tx_byte     = r_tx_byte;

    // next handshake state; a request arriving with byte_done chains straight into SEND
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_byte_req) w_next = SEND;
            end
            SEND: begin
                if (!i_tx_busy) begin
                    w_issue = 1'b1;
                    w_next  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_tx_busy)      w_next = WAIT_LO;
                else if (w_timeout) w_next = IDLE;
            end
            WAIT_LO: begin
                if (w_byte_done)    w_next = i_byte_req ? SEND : IDLE;
                else if (w_timeout) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (i_abort) begin
            w_next  = IDLE;
            w_issue = 1'b0;
        end
    end

    // state register and registered UART request; the byte holds until the next request
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_tx_start <= w_issue;
            if (w_issue) r_tx_byte <= i_byte;
        end
    end

endmodule

// File: rtl/sample_readout.sv
// rtl/sample_readout.sv - sample FIFO to UART readout sequencer, optional READOUT_TIMEOUT_EN watchdog
module sample_readout
    import acsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 8,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [COUNT_WIDTH-1:0]  read_count,
    output logic                    fifo_en,
    output logic                    fifo_rnw,
    input  logic                    fifo_empty,
    input  logic                    fifo_valid,
    input  logic [SAMPLE_WIDTH-1:0] fifo_data,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_byte,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun,
    output logic                    timeout,
    output logic [COUNT_WIDTH-1:0]  sent_count
);

    localparam int BYTES = bytes_per_sample(SAMPLE_WIDTH);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int PAD_W = BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    // outer FSM uses SEND for the whole byte handshake; the sub-module tracks WAIT_HI/WAIT_LO
    readout_state_t          r_state;
    readout_state_t          w_next;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [COUNT_WIDTH-1:0]  r_sent_count;
    logic [COUNT_WIDTH-1:0]  w_sent_inc;
    logic [SAMPLE_WIDTH-1:0] r_sample;
    logic [IDX_W-1:0]        r_byte_idx;
    logic [PAD_W-1:0]        w_padded;
    logic [7:0]              w_cur_byte;
    logic                    r_fifo_en;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_underrun;
    logic                    w_accept;
    logic                    w_fetch;
    logic                    w_underrun_set;
    logic                    w_latch;
    logic                    w_byte_req;
    logic                    w_idx_inc;
    logic                    w_sample_done;
    logic                    w_hs_done;
    logic                    w_hs_timeout;

    assign w_sent_inc = r_sent_count + COUNT_WIDTH'(1);
    assign w_padded   = PAD_W'(r_sample);
    assign w_cur_byte = w_padded[{r_byte_idx, 3'b000} +: 8];

    assign fifo_en    = r_fifo_en;
    assign fifo_rnw   = 1'b1;
    assign busy       = r_busy;
    assign done       = r_done;
    assign underrun   = r_underrun;
    assign sent_count = r_sent_count;

    tx_byte_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hs (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_abort       (abort),
        .i_byte_req    (w_byte_req),
        .i_byte        (w_cur_byte),
        .i_tx_busy     (tx_busy),
        .o_tx_start    (tx_start),
        .o_tx_byte     (tx_byte),
        .o_byte_done   (w_hs_done),
        .o_timeout_hit (w_hs_timeout)
    );

    // next state and per-cycle strobes; abort overrides everything
    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_fetch        = 1'b0;
        w_underrun_set = 1'b0;
        w_latch        = 1'b0;
        w_byte_req     = 1'b0;
        w_idx_inc      = 1'b0;
        w_sample_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (read_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (fifo_empty) begin
                    w_underrun_set = 1'b1;
                    w_next         = DONE;
                end else begin
                    w_fetch = 1'b1;
                    w_next  = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (fifo_valid) begin
                    w_latch    = 1'b1;
                    w_byte_req = 1'b1;
                    w_next     = SEND;
                end
            end
            SEND: begin
                if (w_hs_timeout) begin
                    w_next = DONE;
                end else if (w_hs_done) begin
                    if (r_byte_idx != LAST_IDX) begin
                        w_idx_inc  = 1'b1;
                        w_byte_req = 1'b1;
                    end else begin
                        w_sample_done = 1'b1;
                        w_next        = (w_sent_inc == r_count) ? DONE : FETCH;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (abort) begin
            w_next         = IDLE;
            w_accept       = 1'b0;
            w_fetch        = 1'b0;
            w_underrun_set = 1'b0;
            w_latch        = 1'b0;
            w_byte_req     = 1'b0;
            w_idx_inc      = 1'b0;
            w_sample_done  = 1'b0;
        end
    end

    // state, counters, latched sample and registered status outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_sent_count <= '0;
            r_sample     <= '0;
            r_byte_idx   <= '0;
            r_fifo_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_fifo_en <= w_fetch;
            r_busy    <= (w_next != IDLE);
            r_done    <= (r_state == DONE) && !abort;
            if (w_accept) begin
                r_count      <= read_count;
                r_sent_count <= '0;
                r_underrun   <= 1'b0;
            end
            if (w_underrun_set) r_underrun <= 1'b1;
            if (w_latch) begin
                r_sample   <= fifo_data;
                r_byte_idx <= '0;
            end
            if (w_idx_inc) r_byte_idx <= r_byte_idx + IDX_W'(1);
            if (w_sample_done) begin
                r_byte_idx <= '0;
                if (r_sent_count != '1) r_sent_count <= w_sent_inc;
            end
        end
    end

`ifdef READOUT_TIMEOUT_EN
    logic r_timeout;

    // sticky watchdog flag, cleared when a new readout is accepted
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_timeout <= 1'b0;
        end else if (r_state == SEND && w_hs_timeout && !abort) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sample_readout.sv
// tb/tb_sample_readout.sv - randomized self-checking bench for sample_readout
module tb_sample_readout;

    localparam int SW  = 12;
    localparam int CW  = 16;
    localparam int NB  = (SW + 7) / 8;
    localparam int TMO = 20;

    logic          clock      = 1'b0;
    logic          reset_n    = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic [CW-1:0] read_count = '0;
    logic          fifo_en;
    logic          fifo_rnw;
    logic          fifo_empty = 1'b1;
    logic          fifo_valid = 1'b0;
    logic [SW-1:0] fifo_data  = '0;
    logic          tx_busy    = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          busy;
    logic          done;
    logic          underrun;
    logic          timeout;
    logic [CW-1:0] sent_count;

    sample_readout #(
        .SAMPLE_WIDTH   (SW),
        .COUNT_WIDTH    (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .read_count (read_count),
        .fifo_en    (fifo_en),
        .fifo_rnw   (fifo_rnw),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_data  (fifo_data),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .timeout    (timeout),
        .sent_count (sent_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    logic [SW-1:0] fifo_q[$];
    logic [7:0]    byte_log[$];
    int  n_fifo_en, n_tx_start, n_done, stab_err;
    int  c_busy, c_fifo_en, c_valid, c_tx_start, c_done, c_fall;
    logic [7:0] cur_byte = 8'h00;
    int  busy_len  = 10;
    int  busy_left = 0;
    bit  uart_dead = 1'b0;
    int  clr_seq   = 0;
    int  clr_seen  = 0;

    // FIFO and UART models plus event log, all updated away from the active edge
    always @(negedge clock) begin
        if (clr_seq != clr_seen) begin
            clr_seen   = clr_seq;
            n_fifo_en  = 0; n_tx_start = 0; n_done = 0; stab_err = 0;
            c_busy     = -1; c_fifo_en = -1; c_valid = -1;
            c_tx_start = -1; c_done    = -1; c_fall  = -1;
            byte_log.delete();
        end
        if (busy && c_busy < 0) c_busy = cyc;
        if (fifo_en) begin
            n_fifo_en++;
            if (c_fifo_en < 0) c_fifo_en = cyc;
        end
        if (tx_start) begin
            n_tx_start++;
            if (c_tx_start < 0) c_tx_start = cyc;
            byte_log.push_back(tx_byte);
            cur_byte = tx_byte;
        end
        if (done) begin
            n_done++;
            if (c_done < 0) c_done = cyc;
        end
        if (tx_busy && tx_byte !== cur_byte) stab_err++;
        fifo_valid = 1'b0;
        if (fifo_en && fifo_q.size() > 0) begin
            fifo_data  = fifo_q.pop_front();
            fifo_valid = 1'b1;
            if (c_valid < 0) c_valid = cyc;
        end
        fifo_empty = (fifo_q.size() == 0);
        if (tx_start && !uart_dead) begin
            tx_busy   = 1'b1;
            busy_left = busy_len;
        end else if (tx_busy) begin
            busy_left--;
            if (busy_left == 0) begin
                tx_busy = 1'b0;
                c_fall  = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        clr_seq++;
        tick();
    endtask

    task automatic wait_until_done(input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (n_done > 0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // one readout over the current FIFO contents, checked against a byte-level model
    task automatic run_readout(input int n, input int blen);
        logic [7:0] exp_bytes[$];
        int  avail, m, t0;
        bit  exp_ur, got;
        avail  = fifo_q.size();
        m      = (n < avail) ? n : avail;
        exp_ur = (avail < n);
        for (int i = 0; i < m; i++)
            for (int b = 0; b < NB; b++)
                exp_bytes.push_back(8'(fifo_q[i] >> (8 * b)));
        busy_len = blen;
        clear_logs();
        start      = 1'b1;
        read_count = CW'(n);
        t0         = cyc;
        tick();
        start = 1'b0;
        wait_until_done(4000, got);
        chk("done_seen", 32'(got), 32'd1);
        repeat (4) tick();
        chk("done_pulses", n_done, 1);
        chk("byte_count", byte_log.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < byte_log.size(); i++)
            chk($sformatf("byte%0d", i), 32'(byte_log[i]), 32'(exp_bytes[i]));
        chk("sent_count", 32'(sent_count), m);
        chk("underrun", 32'(underrun), 32'(exp_ur));
        chk("fifo_en_pulses", n_fifo_en, m);
        chk("tx_start_pulses", n_tx_start, m * NB);
        chk("busy_after", 32'(busy), 32'd0);
        chk("tx_byte_stable", stab_err, 0);
`ifndef READOUT_TIMEOUT_EN
        chk("timeout_zero", 32'(timeout), 32'd0);
`endif
        if (n == 0) begin
            chk("zero_done_lat", c_done - t0, 2);
        end else if (m > 0) begin
            chk("start_busy_lat", c_busy - t0, 1);
            chk("start_fifo_en_lat", c_fifo_en - t0, 2);
            chk("valid_tx_start_lat", c_tx_start - c_valid, 2);
            if (!exp_ur) chk("fall_done_lat", c_done - c_fall, 2);
        end
    endtask

    bit got_m;
    int snap_en, snap_tx, rn, ra;

    initial begin
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_fifo_en", 32'(fifo_en), 32'd0);
        chk("rst_fifo_rnw", 32'(fifo_rnw), 32'd1);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_sent_count", 32'(sent_count), 32'd0);
        reset_n = 1'b1;
        tick();

        fifo_q.push_back(12'h011); fifo_q.push_back(12'h022); fifo_q.push_back(12'h033);
        run_readout(3, 10);

        fifo_q.push_back(12'hABC);
        run_readout(1, 3);

        fifo_q.push_back(SW'($urandom_range(0, 4095)));
        fifo_q.push_back(SW'($urandom_range(0, 4095)));
        run_readout(5, 4);

        fifo_q.push_back(12'h5A5);
        run_readout(0, 5);
        fifo_q.delete();
        tick();

        // abort while the first byte of sample 2 is in WAIT_LO
        for (int i = 0; i < 4; i++) fifo_q.push_back(SW'($urandom_range(0, 4095)));
        busy_len = 6;
        clear_logs();
        start = 1'b1; read_count = CW'(4);
        tick();
        start = 1'b0;
        got_m = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (n_tx_start == NB + 1 && tx_busy) begin
                got_m = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reached", 32'(got_m), 32'd1);
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        snap_en = n_fifo_en;
        snap_tx = n_tx_start;
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_sent", 32'(sent_count), 32'd1);
        repeat (40) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_no_fifo_en", n_fifo_en, snap_en);
        chk("abort_no_tx_start", n_tx_start, snap_tx);
        fifo_q.delete();
        fifo_q.push_back(12'h3C1); fifo_q.push_back(12'h0FF);
        run_readout(2, 5);

        // reset in the middle of a readout
        for (int i = 0; i < 3; i++) fifo_q.push_back(SW'($urandom_range(0, 4095)));
        busy_len = 5;
        clear_logs();
        start = 1'b1; read_count = CW'(3);
        tick();
        start = 1'b0;
        got_m = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (n_tx_start == 2) begin
                got_m = 1'b1;
                break;
            end
            tick();
        end
        chk("reset_reached", 32'(got_m), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sent", 32'(sent_count), 32'd0);
        repeat (40) tick();
        chk("reset_no_done", n_done, 0);
        fifo_q.delete();
        tick();

        // UART that never raises busy
        fifo_q.push_back(12'h1E7);
        uart_dead = 1'b1;
        clear_logs();
        start = 1'b1; read_count = CW'(1);
        tick();
        start = 1'b0;
`ifdef READOUT_TIMEOUT_EN
        wait_until_done(300, got_m);
        chk("wd_done_seen", 32'(got_m), 32'd1);
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_done_lat", c_done - c_tx_start, TMO + 1);
        chk("wd_sent", 32'(sent_count), 32'd0);
        tick();
        chk("wd_busy", 32'(busy), 32'd0);
`else
        repeat (300) tick();
        chk("hang_no_done", n_done, 0);
        chk("hang_busy", 32'(busy), 32'd1);
        chk("hang_timeout", 32'(timeout), 32'd0);
        chk("hang_tx_start", n_tx_start, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("hang_abort_idle", 32'(busy), 32'd0);
`endif
        uart_dead = 1'b0;
        fifo_q.delete();
        tick();

        for (int r = 0; r < 10; r++) begin
            rn = $urandom_range(0, 6);
            ra = $urandom_range(0, 6);
            for (int i = 0; i < ra; i++) fifo_q.push_back(SW'($urandom_range(0, 4095)));
            run_readout(rn, $urandom_range(1, 12));
            fifo_q.delete();
            repeat (2) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
